pps_aligned_pulse_gen: RTL and testbench
========================================

Name: pps_aligned_pulse_gen

Overview:
- Generates a 50 Hz strobe, one CLK cycle wide, from the 3.2768 MHz sampling clock.
- The strobe is phase-aligned to rising edges of an asynchronous external timing signal (SIG, e.g. PPS).
- Internal chain: SIG synchroniser and rising-edge detector, then sync/realign control, then a divide-by-65536 strobe counter.
- Sits at the front of the ADC timing chain; PULSE_50_HZ triggers the sample-frame logic.

Parameters:
CLK_FREQ_HZ, 3276800, frequency of CLK in Hz
PULSE_FREQ_HZ, 50, output strobe rate in Hz
SYNC_STAGES, 2, flip-flops in the SIG metastability synchroniser (minimum 2)

Ports:
CLK  input  1  system clock, 3.2768 MHz; all logic on its rising edge
RST  input  1  reset, synchronous, active-high
SIG  input  1  asynchronous external timing reference; rising edge defines phase
POSEDGE  output  1  one-cycle pulse on each synchronised rising edge of SIG
SYNCED  output  1  high once the first SIG rising edge has been seen since reset
PULSE_50_HZ  output  1  one-cycle strobe at PULSE_FREQ_HZ, aligned to SIG

Behaviour:
- One clock, CLK. Reset is synchronous and active-high (RST).
- DIVISOR = CLK_FREQ_HZ / PULSE_FREQ_HZ, which is 65536 with the defaults.
- Elaboration error if DIVISOR is not an exact integer or is less than 2, or if SYNC_STAGES is less than 2.
- Counter CNT is $clog2(DIVISOR) bits wide (16 with defaults).
- Reset, with RST high at a rising edge:
  - synchroniser flops, the edge-history flop, SYNCED and CNT all clear to 0;
  - POSEDGE = 0 and PULSE_50_HZ = 0 in the following cycle.
- RST has priority over every other event, including a simultaneous POSEDGE.
- Edge detect:
  - SIG passes through the SYNC_STAGES-flop synchroniser into s_sync; s_prev is s_sync delayed by one cycle.
  - POSEDGE = s_sync & ~s_prev, combinational from registers.
  - Latency with defaults: POSEDGE is high for exactly one cycle, following the 3rd rising CLK edge at which SIG is sampled high. The 3rd edge counts from the first edge at which SIG is sampled high.
  - SIG held high produces no further pulses; a falling edge produces no pulse.
  - After reset, SIG already high yields a POSEDGE, because history resets to 0.
- Sync control, at a rising edge with POSEDGE = 1 and RST = 0:
  - SYNCED <= 1 (sticky until RST);
  - CNT <= 0.
  - This realigns the phase on every SIG edge, not only the first.
- Counter:
  - While SYNCED = 0, CNT holds 0.
  - While SYNCED = 1 and no POSEDGE: CNT <= (CNT == DIVISOR-1) ? 0 : CNT+1.
- Strobe:
  - PULSE_50_HZ = SYNCED & (CNT == 0), combinational from registers.
  - The first strobe occurs in the cycle after the aligning POSEDGE cycle, then every DIVISOR cycles.
- Realign mid-period: a POSEDGE at any CNT value forces the next strobe one cycle later.
  - The period containing the realign is shortened or lengthened; no double strobe in adjacent cycles except when POSEDGE occurs at CNT == 0.
  - A POSEDGE at CNT == DIVISOR-1 is indistinguishable from the natural wrap.
- RST mid-operation: SYNCED drops, strobes stop, and the block waits for a new SIG rising edge.
- All outputs are glitch-free functions of registers only; there are no combinational paths from SIG.

Decomposition:
- Shared package timing_pkg holds:
  - CLK_FREQ_HZ = 3_276_800
  - PULSE_FREQ_HZ = 50
  - derived localparams DIVISOR and CNT_W, used as parameter defaults.
- One natural sub-module, sig_edge_sync. It takes CLK, RST and SIG, contains the synchroniser and edge history, and outputs POSEDGE.
- Sync control and the counter live in the top module.

Test Plan:
1. RST high for 5 cycles, SIG = 0 for 200000 cycles:
   - POSEDGE, SYNCED and PULSE_50_HZ stay 0 throughout.
2. Release reset, raise SIG at cycle 1000 and hold:
   - POSEDGE is high for 1 cycle, 3 edges after sampling.
   - SYNCED rises the next cycle.
   - PULSE_50_HZ fires the cycle after POSEDGE, then at +65536 and +131072, each 1 cycle wide.
3. While synced, pulse SIG low then high so that POSEDGE lands at CNT = 30000:
   - the next strobe comes 1 cycle after POSEDGE;
   - subsequent strobes are spaced 65536 cycles from the new origin.
4. Random SIG: low for 1000–10000 cycles, high for 10000–100000 cycles:
   - every strobe occurs exactly k·65536+1 cycles after the latest POSEDGE;
   - there is exactly one POSEDGE per SIG rise.
5. Assert RST for 1 cycle at CNT = 40000, simultaneous with a POSEDGE:
   - SYNCED = 0, CNT = 0 and no strobe until the next SIG rise;
   - RST wins over POSEDGE.
6. Glitch check: SIG high for only 1 ns between CLK edges:
   - at most one POSEDGE results; no X appears on any output.

Source files
------------

// File: rtl/timing_pkg.sv
//------------------------------------------------------------------------------
// Module : timing_pkg
// Brief  : Shared clock/strobe rates for the ADC timing chain.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package timing_pkg;
  localparam int CLK_FREQ_HZ   = 3_276_800;
  localparam int PULSE_FREQ_HZ = 50;
  localparam int DIVISOR       = CLK_FREQ_HZ / PULSE_FREQ_HZ;
  localparam int CNT_W         = $clog2(DIVISOR);
endpackage

`default_nettype wire

// File: rtl/sig_edge_sync.sv
//------------------------------------------------------------------------------
// Module : sig_edge_sync
// Brief  : Metastability synchroniser for SIG plus single-cycle rising-edge detect.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sig_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic SIG,
  output logic POSEDGE
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_sync;
  logic                   r_s_prev;

  // s_sync is taken one register past the synchroniser chain, so the edge
  // shows up after the third CLK edge that samples SIG high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= '0;
      r_s_sync <= 1'b0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], SIG};
      r_s_sync <= r_sync[SYNC_STAGES-1];
      r_s_prev <= r_s_sync;
    end
  end

  assign POSEDGE = r_s_sync & ~r_s_prev;

endmodule

`default_nettype wire

// File: rtl/pps_aligned_pulse_gen.sv
//------------------------------------------------------------------------------
// Module : pps_aligned_pulse_gen
// Brief  : PULSE_FREQ_HZ strobe from CLK, phase-realigned on every SIG rising edge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pps_aligned_pulse_gen #(
  parameter int CLK_FREQ_HZ   = timing_pkg::CLK_FREQ_HZ,
  parameter int PULSE_FREQ_HZ = timing_pkg::PULSE_FREQ_HZ,
  parameter int SYNC_STAGES   = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic SIG,
  output logic POSEDGE,
  output logic SYNCED,
  output logic PULSE_50_HZ
);

  localparam int DIVISOR = CLK_FREQ_HZ / PULSE_FREQ_HZ;
  localparam int CNT_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DIVISOR - 1);

  if (((CLK_FREQ_HZ % PULSE_FREQ_HZ) != 0) || (DIVISOR < 2) || (SYNC_STAGES < 2))
  begin : g_param_check
    $error("pps_aligned_pulse_gen: DIVISOR must be an exact integer >= 2 and SYNC_STAGES >= 2");
  end

  logic             w_posedge;
  logic             r_synced;
  logic [CNT_W-1:0] r_cnt;

  sig_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sig_edge_sync (
    .CLK     (CLK),
    .RST     (RST),
    .SIG     (SIG),
    .POSEDGE (w_posedge)
  );

  // Every SIG edge restarts the period, so the strobe follows one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_synced <= 1'b0;
      r_cnt    <= '0;
    end else if (w_posedge) begin
      r_synced <= 1'b1;
      r_cnt    <= '0;
    end else if (r_synced) begin
      r_cnt    <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
    end
  end

  assign POSEDGE     = w_posedge;
  assign SYNCED      = r_synced;
  assign PULSE_50_HZ = r_synced & (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_pps_aligned_pulse_gen.sv
//------------------------------------------------------------------------------
// Module : tb_pps_aligned_pulse_gen
// Brief  : Directed + random bench with a cycle-indexed reference model (DIVISOR scaled to 200).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pps_aligned_pulse_gen;

  localparam int CLK_HZ = 3_276_800;
  localparam int PLS_HZ = 16_384;
  localparam int DIV    = CLK_HZ / PLS_HZ;   // 200

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SIG = 1'b0;
  logic POSEDGE, SYNCED, PULSE_50_HZ;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: SIG samples at the last four edges, cycle index,
  // index of the latest POSEDGE cycle, and expected outputs.
  bit h0, h1, h2, h3;
  int cyc = 0;
  int p   = 0;
  bit m_pe, m_synced, m_pulse;
  int n_pe_obs = 0;

  pps_aligned_pulse_gen #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .PULSE_FREQ_HZ (PLS_HZ),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SIG         (SIG),
    .POSEDGE     (POSEDGE),
    .SYNCED      (SYNCED),
    .PULSE_50_HZ (PULSE_50_HZ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int mcnt();
    return (cyc - p - 1) % DIV;
  endfunction

  // One CLK cycle: advance the model on the edge, then compare #1 later.
  task automatic step();
    bit rs, sg;
    @(posedge CLK);
    rs = RST;
    sg = SIG;
    if (rs) begin
      m_synced = 1'b0;
      {h0, h1, h2, h3} = 4'b0;
      m_pe = 1'b0;
    end else begin
      if (m_pe) begin
        m_synced = 1'b1;
        p = cyc;
      end
      h3 = h2; h2 = h1; h1 = h0; h0 = sg;
      m_pe = h2 & ~h3;
    end
    cyc++;
    m_pulse = m_synced && (((cyc - p - 1) % DIV) == 0);
    #1;
    if (POSEDGE === 1'b1) n_pe_obs++;
    check("posedge", POSEDGE, m_pe);
    check("synced", SYNCED, m_synced);
    check("pulse", PULSE_50_HZ, m_pulse);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until_cnt(input int target);
    int k;
    k = 0;
    while (mcnt() != target && k < 2 * DIV) begin
      step();
      k++;
    end
    check_int("cnt_align_timeout", mcnt(), target);
  endtask

  initial begin
    int rises, pe_base, pe_cnt, seen;

    // 1. reset then idle SIG
    RST = 1'b1; SIG = 1'b0;
    steps(5);
    check("rst_posedge", POSEDGE, 1'b0);
    check("rst_synced", SYNCED, 1'b0);
    check("rst_pulse", PULSE_50_HZ, 1'b0);
    RST = 1'b0;
    steps(2000);
    check("idle_synced", SYNCED, 1'b0);

    // 2. first rising edge: latency and periodic strobes
    steps(100);
    SIG = 1'b1;
    step(); check("lat_e1", POSEDGE, 1'b0);
    step(); check("lat_e2", POSEDGE, 1'b0);
    step(); check("lat_e3", POSEDGE, 1'b1);
    step();
    check("first_posedge_gone", POSEDGE, 1'b0);
    check("first_synced", SYNCED, 1'b1);
    check("first_strobe", PULSE_50_HZ, 1'b1);
    step(); check("strobe_width", PULSE_50_HZ, 1'b0);
    steps(DIV - 1); check("strobe_p1", PULSE_50_HZ, 1'b1);
    steps(DIV);     check("strobe_p2", PULSE_50_HZ, 1'b1);

    // 3. realign at counter value 120
    SIG = 1'b0;
    steps(6);
    step_until_cnt(117);
    SIG = 1'b1;
    steps(3);
    check("realign_posedge", POSEDGE, 1'b1);
    step(); check("realign_strobe", PULSE_50_HZ, 1'b1);
    steps(DIV); check("realign_next", PULSE_50_HZ, 1'b1);

    // 4. random SIG
    rises = 0;
    pe_base = n_pe_obs;
    for (int r = 0; r < 4; r++) begin
      SIG = 1'b0;
      steps(int'($urandom_range(100, 10)));
      SIG = 1'b1;
      rises++;
      steps(int'($urandom_range(1000, 100)));
    end
    check_int("one_posedge_per_rise", n_pe_obs - pe_base, rises);

    // 5. reset coinciding with POSEDGE at counter value 160
    SIG = 1'b0;
    steps(6);
    step_until_cnt(157);
    SIG = 1'b1;
    steps(3);
    check("rst_race_posedge", POSEDGE, 1'b1);
    RST = 1'b1; SIG = 1'b0;
    step();
    RST = 1'b0;
    check("rst_wins_synced", SYNCED, 1'b0);
    pe_cnt = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      if (PULSE_50_HZ !== 1'b0) pe_cnt++;
    end
    check_int("no_strobe_after_rst", pe_cnt, 0);
    SIG = 1'b1;
    steps(4);
    check("resync", SYNCED, 1'b1);
    steps(DIV + 5);

    // 6. 1 ns glitch between edges
    SIG = 1'b0;
    steps(5);
    pe_base = n_pe_obs;
    #2 SIG = 1'b1;
    #1 SIG = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ($isunknown({POSEDGE, SYNCED, PULSE_50_HZ})) seen++;
    end
    check_int("glitch_no_x", seen, 0);
    n_chk++;
    assert ((n_pe_obs - pe_base) <= 1) else begin
      n_fail++;
      $error("FAIL glitch_posedges observed=%0d expected<=1", n_pe_obs - pe_base);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
